// File: rtl/serial_pkg.sv
// Shared types and default widths for the serial feed/summer pair.
// The feed FSM encoding lives here so both blocks agree on it.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } feed_state_e;

    localparam int DATA_W_DEF = 8;
    localparam int N_W_DEF    = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head and occupancy count.
// A push while full is taken only if a pop frees a slot that cycle.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr;
    logic [AW-1:0]     r_rd;
    logic [LW-1:0]     r_level;
    logic              w_push;
    logic              w_pop;

    assign full   = (r_level == LW'(DEPTH));
    assign empty  = (r_level == '0);
    assign level  = r_level;
    assign head   = empty ? '0 : r_mem[r_rd];
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);

    // Storage array; contents need no reset, head is masked while empty.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH; level tracks push minus pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/serial_feed.sv
// Preloaded word streamer: sends n buffered words on start, then done.
// A start asking for more words than are buffered is refused.
module serial_feed
    import serial_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 16,
    parameter int N_W    = N_W_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wr_en_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o,
    input  logic                     start_i,
    input  logic [N_W-1:0]           n_i,
    output logic                     busy_o,
    output logic [DATA_W-1:0]        data_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     done_o,
    output logic                     reject_o
);

    localparam int LW = $clog2(DEPTH) + 1;

    feed_state_e          r_state;
    feed_state_e          w_next;
    logic [N_W-1:0]       r_remaining;
    logic                 r_reject;
    logic                 w_empty;
    logic                 w_hs;
    logic                 w_zero_n;
    logic                 w_too_many;
    logic                 w_last;
    logic [N_W+LW-1:0]    w_n_ext;
    logic [N_W+LW-1:0]    w_lvl_ext;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push      (wr_en_i),
        .push_data (wr_data_i),
        .pop       (w_hs),
        .head      (data_o),
        .level     (level_o),
        .full      (full_o),
        .empty     (w_empty)
    );

    assign w_hs       = valid_o & ready_i & ~w_empty;
    assign w_n_ext    = {{LW{1'b0}}, n_i};
    assign w_lvl_ext  = {{N_W{1'b0}}, level_o};
    assign w_zero_n   = (n_i == '0);
    assign w_too_many = (w_n_ext > w_lvl_ext);
    assign w_last     = (r_remaining == {{(N_W-1){1'b0}}, 1'b1});

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: start check in IDLE, last handshake ends SEND.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (start_i) begin
                    if (w_zero_n) begin
                        w_next = DONE;
                    end else if (!w_too_many) begin
                        w_next = SEND;
                    end
                end
            end
            SEND: begin
                if (w_hs && w_last) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Word counter and registered reject pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_remaining <= '0;
            r_reject    <= 1'b0;
        end else begin
            r_reject <= 1'b0;
            if (r_state == IDLE && start_i) begin
                r_remaining <= n_i;
                r_reject    <= ~w_zero_n & w_too_many;
            end else if (r_state == SEND && w_hs) begin
                r_remaining <= r_remaining - {{(N_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // State-decoded outputs.
    always_comb begin
        valid_o  = (r_state == SEND);
        done_o   = (r_state == DONE);
        busy_o   = (r_state == SEND) | (r_state == DONE);
        reject_o = r_reject;
    end

endmodule

// File: tb/tb_serial_feed.sv
// Scoreboard bench for serial_feed: expected words are queued by the
// stimulus and popped by a monitor on every handshake.
module tb_serial_feed;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int N_W    = 8;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              full;
    logic [LW-1:0]     level;
    logic              start = 1'b0;
    logic [N_W-1:0]    n = '0;
    logic              busy;
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready = 1'b0;
    logic              done;
    logic              reject;

    int n_checks = 0;
    int n_errors = 0;
    logic [DATA_W-1:0] exp_q [$];

    serial_feed #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .N_W    (N_W)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .wr_en_i   (wr_en),
        .wr_data_i (wr_data),
        .full_o    (full),
        .level_o   (level),
        .start_i   (start),
        .n_i       (n),
        .busy_o    (busy),
        .data_o    (data),
        .valid_o   (valid),
        .ready_i   (ready),
        .done_o    (done),
        .reject_o  (reject)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [DATA_W-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic go(input logic [N_W-1:0] cnt);
        start = 1'b1;
        n     = cnt;
        tick();
        start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_word: got %0h expected none", data);
            end else begin
                logic [DATA_W-1:0] e;
                e = exp_q.pop_front();
                if (data != e) begin
                    n_errors++;
                    $display("FAIL stream_word: got %0h expected %0h", data, e);
                end
            end
        end
    end

    initial begin
        // reset state
        #2;
        check("rst_level", int'(level), 0);
        check("rst_outs", int'({valid, done, busy, full, reject}), 0);
        check("rst_data", int'(data), 0);
        #10;
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("idle_outs",
                int'({valid, done, busy, full, reject, level, data}), 0);
            tick();
        end

        // basic stream
        ready = 1'b1;
        wr(8'd3); wr(8'd5); wr(8'd7); wr(8'd9);
        check("basic_level", int'(level), 4);
        exp_q.push_back(8'd3); exp_q.push_back(8'd5);
        exp_q.push_back(8'd7); exp_q.push_back(8'd9);
        go(8'd4);
        for (int i = 0; i < 4; i++) begin
            check("basic_valid", int'(valid), 1);
            check("basic_busy", int'(busy), 1);
            tick();
        end
        check("basic_done", int'(done), 1);
        check("basic_done_valid", int'(valid), 0);
        tick();
        check("basic_done_pulse", int'(done), 0);
        check("basic_level_end", int'(level), 0);
        check("basic_busy_end", int'(busy), 0);

        // backpressure
        ready = 1'b0;
        wr(8'h11); wr(8'h22);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        go(8'd2);
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", int'(valid), 1);
            check("stall_data", int'(data), 'h11);
            tick();
        end
        ready = 1'b1;
        tick();
        check("bp_second", int'(data), 'h22);
        tick();
        check("bp_done", int'(done), 1);
        tick();
        check("bp_done_pulse", int'(done), 0);
        check("bp_queue", exp_q.size(), 0);

        // reject, then a start that fits
        wr(8'hA1); wr(8'hA2);
        go(8'd5);
        check("rej_pulse", int'(reject), 1);
        check("rej_state", int'({valid, busy}), 0);
        check("rej_level", int'(level), 2);
        tick();
        check("rej_pulse_end", int'(reject), 0);
        check("rej_valid", int'(valid), 0);
        exp_q.push_back(8'hA1); exp_q.push_back(8'hA2);
        go(8'd2);
        check("follow_valid", int'(valid), 1);
        tick();
        tick();
        check("follow_done", int'(done), 1);
        tick();

        // fill past full, then write and pop together while full
        for (int i = 0; i < DEPTH + 1; i++) begin
            wr(DATA_W'(8'h40 + i));
        end
        check("full_level", int'(level), 16);
        check("full_flag", int'(full), 1);
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back(DATA_W'(8'h40 + i));
        end
        go(8'd16);
        wr(8'h99);
        check("wrpop_level", int'(level), 16);
        check("wrpop_full", int'(full), 1);
        for (int i = 0; i < 15; i++) tick();
        check("full_done", int'(done), 1);
        tick();
        check("leftover_level", int'(level), 1);
        exp_q.push_back(8'h99);
        go(8'd1);
        tick();
        check("leftover_done", int'(done), 1);
        tick();
        check("leftover_empty", int'(level), 0);

        // zero-length start
        go(8'd0);
        check("zero_done", int'(done), 1);
        check("zero_valid", int'(valid), 0);
        tick();
        check("zero_done_end", int'(done), 0);

        // reset in the middle of a transfer
        for (int i = 0; i < 8; i++) begin
            wr(DATA_W'(8'h80 + i));
        end
        exp_q.push_back(8'h80); exp_q.push_back(8'h81);
        exp_q.push_back(8'h82);
        go(8'd8);
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        check("arst_outs", int'({valid, done, busy, full}), 0);
        check("arst_level", int'(level), 0);
        check("arst_data", int'(data), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("arst_queue", exp_q.size(), 0);
        check("arst_idle", int'({valid, busy, done}), 0);
        go(8'd1);
        check("arst_reject", int'(reject), 1);
        check("arst_novalid", int'(valid), 0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
